// File: rtl/johnson_counter.sv
// 4-stage self-correcting Johnson counter: 8-state twisted ring with phase index
// and illegal-code flag; optional forced recovery from parasitic states.
module johnson_counter #(
  parameter logic [3:0] INIT_STATE = 4'b0000,
  parameter bit         RECOVER    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  output logic       q0,
  output logic       q1,
  output logic       q2,
  output logic       q3,
  output logic [2:0] phase,
  output logic       illegal
);

  localparam int unsigned STAGES = 4;
  localparam int unsigned PHASE_W = 3;

  // r_state is {q0,q1,q2,q3}: bit 3 is the ring input stage
  logic [STAGES-1:0]  r_state;
  logic [STAGES-1:0]  w_next;
  logic [PHASE_W-1:0] w_phase;
  logic               w_illegal;

  // Decode the current code into its phase; anything off the ring is illegal
  always_comb begin
    w_phase   = PHASE_W'(0);
    w_illegal = 1'b0;
    case (r_state)
      4'b0000: w_phase = 3'd0;
      4'b1000: w_phase = 3'd1;
      4'b1100: w_phase = 3'd2;
      4'b1110: w_phase = 3'd3;
      4'b1111: w_phase = 3'd4;
      4'b0111: w_phase = 3'd5;
      4'b0011: w_phase = 3'd6;
      4'b0001: w_phase = 3'd7;
      default: w_illegal = 1'b1;
    endcase
  end

  // Twisted shift: inverted last stage feeds the first
  always_comb begin
    w_next = {~r_state[0], r_state[STAGES-1:1]};
    if (RECOVER && w_illegal) begin
      w_next = INIT_STATE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= INIT_STATE;
    end else begin
      r_state <= w_next;
    end
  end

  assign q0      = r_state[3];
  assign q1      = r_state[2];
  assign q2      = r_state[1];
  assign q3      = r_state[0];
  assign phase   = w_phase;
  assign illegal = w_illegal;

endmodule

// File: tb/tb_johnson_counter.sv
// Self-checking bench for johnson_counter: three parameterisations checked
// against a table-driven phase model of the twisted ring.
module tb_johnson_counter;

  logic       clk;
  logic       reset;
  logic [2:0] q0_w, q1_w, q2_w, q3_w, ill_w;
  logic [2:0] ph0, ph1, ph2;

  int checks;
  int failures;

  // Reference ring by phase index, codes written as {q0,q1,q2,q3}
  logic [3:0] ring [8];
  logic [3:0] bad  [8];
  logic [3:0] m    [3];
  logic [3:0] init_v [3];
  bit         rec_v  [3];

  johnson_counter #(.INIT_STATE(4'b0000), .RECOVER(1'b1)) dut0 (
    .clk(clk), .reset(reset), .q0(q0_w[0]), .q1(q1_w[0]), .q2(q2_w[0]), .q3(q3_w[0]),
    .phase(ph0), .illegal(ill_w[0]));
  johnson_counter #(.INIT_STATE(4'b1111), .RECOVER(1'b1)) dut1 (
    .clk(clk), .reset(reset), .q0(q0_w[1]), .q1(q1_w[1]), .q2(q2_w[1]), .q3(q3_w[1]),
    .phase(ph1), .illegal(ill_w[1]));
  johnson_counter #(.INIT_STATE(4'b0000), .RECOVER(1'b0)) dut2 (
    .clk(clk), .reset(reset), .q0(q0_w[2]), .q1(q1_w[2]), .q2(q2_w[2]), .q3(q3_w[2]),
    .phase(ph2), .illegal(ill_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] obs(input int i);
    return {q0_w[i], q1_w[i], q2_w[i], q3_w[i]};
  endfunction

  function automatic logic [2:0] obs_phase(input int i);
    case (i)
      0:       return ph0;
      1:       return ph1;
      default: return ph2;
    endcase
  endfunction

  function automatic int ring_index(input logic [3:0] code);
    for (int k = 0; k < 8; k++) if (ring[k] == code) return k;
    return -1;
  endfunction

  function automatic logic [3:0] model_next(input logic [3:0] code, input int i);
    int k;
    logic a, b, c, d;
    k = ring_index(code);
    if (k >= 0) return ring[(k + 1) % 8];
    if (rec_v[i]) return init_v[i];
    {a, b, c, d} = code;
    return {~d, a, b, c};
  endfunction

  function automatic logic [2:0] model_phase(input logic [3:0] code);
    int k;
    k = ring_index(code);
    return (k < 0) ? 3'd0 : 3'(k);
  endfunction

  function automatic int popcount4(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  // One rising edge; the model follows reset as seen at that edge
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) m[i] = (reset == 1'b0) ? init_v[i] : model_next(m[i], i);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) m[i] = init_v[i];
    for (int e = 0; e < 2; e++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== init_v[i]) begin
          failures++;
          $display("FAIL reset_state dut%0d edge%0d got=%b exp=%b", i, e, obs(i), init_v[i]);
        end
        checks++;
        if (obs_phase(i) !== model_phase(init_v[i]) || ill_w[i] !== 1'b0) begin
          failures++;
          $display("FAIL reset_flags dut%0d got phase=%0d ill=%b exp phase=%0d ill=0",
                   i, obs_phase(i), ill_w[i], model_phase(init_v[i]));
        end
      end
    end
  endtask

  task automatic test_full_cycle();
    logic [2:0] exp_ph [8];
    exp_ph = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    reset = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      checks++;
      if (obs(0) !== ring[(e + 1) % 8] || ph0 !== exp_ph[e] || ill_w[0] !== 1'b0) begin
        failures++;
        $display("FAIL full_cycle edge%0d got=%b ph=%0d ill=%b exp=%b ph=%0d ill=0",
                 e + 1, obs(0), ph0, ill_w[0], ring[(e + 1) % 8], exp_ph[e]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] prev;
    for (int e = 1; e <= 16; e++) begin
      prev = obs(0);
      step();
      checks++;
      if (popcount4(prev ^ obs(0)) != 1 || obs(0) !== m[0]) begin
        failures++;
        $display("FAIL wrap_step edge%0d prev=%b got=%b exp=%b", e, prev, obs(0), m[0]);
      end
      if (e == 8 || e == 16) begin
        checks++;
        if (obs(0) !== 4'b0000) begin
          failures++;
          $display("FAIL wrap_zero edge%0d got=%b exp=0000", e, obs(0));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int e = 0; e < 3; e++) step();
    checks++;
    if (obs(0) !== 4'b1110) begin
      failures++;
      $display("FAIL async_pre got=%b exp=1110", obs(0));
    end
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) m[i] = init_v[i];
    #1;
    checks++;
    if (obs(0) !== 4'b0000 || obs(1) !== 4'b1111) begin
      failures++;
      $display("FAIL async_immediate got=%b/%b exp=0000/1111", obs(0), obs(1));
    end
    for (int e = 0; e < 2; e++) begin
      step();
      checks++;
      if (obs(0) !== 4'b0000) begin
        failures++;
        $display("FAIL async_hold edge%0d got=%b exp=0000", e, obs(0));
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_illegal_recovery();
    logic [3:0] code;
    for (int t = 0; t < 6; t++) begin
      code = (t == 0) ? 4'b0101 : bad[$urandom_range(0, 7)];
      for (int n = $urandom_range(0, 7); n > 0; n--) step();
      force dut0.r_state = code;
      #1;
      m[0] = code;
      checks++;
      if (ill_w[0] !== 1'b1 || ph0 !== 3'd0) begin
        failures++;
        $display("FAIL illegal_flag code=%b got ill=%b ph=%0d exp ill=1 ph=0", code, ill_w[0], ph0);
      end
      release dut0.r_state;
      step();
      checks++;
      if (obs(0) !== m[0] || ill_w[0] !== 1'b0) begin
        failures++;
        $display("FAIL illegal_recover code=%b got=%b ill=%b exp=%b ill=0", code, obs(0), ill_w[0], m[0]);
      end
    end
  endtask

  task automatic test_init_state();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) m[i] = init_v[i];
    checks++;
    if (obs(1) !== 4'b1111 || ph1 !== 3'd4) begin
      failures++;
      $display("FAIL init_reset got=%b ph=%0d exp=1111 ph=4", obs(1), ph1);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    step();
    checks++;
    if (obs(1) !== 4'b0111 || ph1 !== 3'd5) begin
      failures++;
      $display("FAIL init_first_edge got=%b ph=%0d exp=0111 ph=5", obs(1), ph1);
    end
  endtask

  task automatic test_no_recover();
    logic [3:0] code;
    logic [3:0] start;
    code = bad[$urandom_range(0, 7)];
    force dut2.r_state = code;
    #1;
    release dut2.r_state;
    m[2] = code;
    start = code;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (obs(2) !== m[2] || ill_w[2] !== 1'b1 || ph2 !== 3'd0) begin
        failures++;
        $display("FAIL parasitic edge%0d start=%b got=%b ill=%b exp=%b ill=1", e, start, obs(2), ill_w[2], m[2]);
      end
    end
    checks++;
    if (obs(2) !== start) begin
      failures++;
      $display("FAIL parasitic_loop got=%b exp=%b", obs(2), start);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b0;
        for (int i = 0; i < 3; i++) m[i] = init_v[i];
      end else begin
        reset = 1'b1;
      end
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== m[i] || obs_phase(i) !== model_phase(m[i]) ||
            ill_w[i] !== ((ring_index(m[i]) < 0) ? 1'b1 : 1'b0)) begin
          failures++;
          $display("FAIL random dut%0d t=%0d got=%b ph=%0d ill=%b exp=%b ph=%0d",
                   i, t, obs(i), obs_phase(i), ill_w[i], m[i], model_phase(m[i]));
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ring   = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
    bad    = '{4'b0100, 4'b1010, 4'b0101, 4'b1001, 4'b0010, 4'b0110, 4'b1011, 4'b1101};
    init_v = '{4'b0000, 4'b1111, 4'b0000};
    rec_v  = '{1'b1, 1'b1, 1'b0};
    reset  = 1'b0;
    test_reset();
    test_full_cycle();
    test_wrap();
    test_async_reset();
    test_illegal_recovery();
    test_init_state();
    test_no_recover();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
